// File: rtl/kernel_kcore_start_fanout_fifo.sv
// Start-token FIFO that broadcasts each queued token to NUM_CH consumer channels.
// An entry retires only once every channel has read it; occupancy and almost-full are reported.
module kernel_kcore_start_fanout_fifo #(
    parameter int unsigned DATA_WIDTH   = 1,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ADDR_WIDTH   = 2,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned AFULL_MARGIN = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_almost_full,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic [NUM_CH-1:0]     if_empty_n,
    input  logic [NUM_CH-1:0]     if_read_ce,
    input  logic [NUM_CH-1:0]     if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);

    localparam logic [ADDR_WIDTH:0] CntOne   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CntDepth = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CntAfull = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [NUM_CH-1:0]     done_q, done_d;

    logic                  wr;
    logic                  pop;
    logic                  not_empty;
    logic [NUM_CH-1:0]     rd;
    logic [ADDR_WIDTH-1:0] head_idx;

    assign not_empty = (count_q != '0);
    assign wr        = if_write & if_write_ce & if_full_n;
    assign rd        = if_read & if_read_ce & if_empty_n;
    assign pop       = not_empty & (&(done_q | rd));

    // Oldest entry sits at count-1; a concurrent push shifts the next-oldest into that slot.
    assign head_idx  = ADDR_WIDTH'(count_q - CntOne);

    always_comb begin
        count_d = count_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        done_d = done_q | rd;
        if (pop) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            done_q  <= '0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[0] <= if_din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign if_full_n      = (count_q != CntDepth);
    assign if_almost_full = (count_q >= CntAfull);
    assign if_count       = count_q;
    assign if_empty_n     = {NUM_CH{not_empty}} & ~done_q;
    assign if_dout        = mem_q[head_idx];

endmodule

// File: tb/tb_kernel_kcore_start_fanout_fifo.sv
// Directed table-driven bench for the fanout start FIFO (DEPTH=4, NUM_CH=2, 8-bit tokens).
module tb_kernel_kcore_start_fanout_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       if_full_n;
    logic       if_write_ce;
    logic       if_write;
    logic [7:0] if_din;
    logic       if_almost_full;
    logic [2:0] if_count;
    logic [1:0] if_empty_n;
    logic [1:0] if_read_ce;
    logic [1:0] if_read;
    logic [7:0] if_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kernel_kcore_start_fanout_fifo #(
        .DATA_WIDTH  (8),
        .DEPTH       (4),
        .ADDR_WIDTH  (2),
        .NUM_CH      (2),
        .AFULL_MARGIN(1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_full_n     (if_full_n),
        .if_write_ce   (if_write_ce),
        .if_write      (if_write),
        .if_din        (if_din),
        .if_almost_full(if_almost_full),
        .if_count      (if_count),
        .if_empty_n    (if_empty_n),
        .if_read_ce    (if_read_ce),
        .if_read       (if_read),
        .if_dout       (if_dout)
    );

    typedef struct {
        logic       wr;
        logic       wr_ce;
        logic [7:0] din;
        logic [1:0] rd;
        logic [1:0] rd_ce;
        logic [2:0] cnt;
        logic [1:0] en;
        logic       fn;
        logic       af;
        logic       chk_dout;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic wr_ce, logic [7:0] din, logic [1:0] rd,
                                logic [1:0] rd_ce, logic [2:0] cnt, logic [1:0] en,
                                logic fn, logic af, logic chk_dout, logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.wr_ce = wr_ce; v.din = din; v.rd = rd; v.rd_ce = rd_ce;
        v.cnt = cnt; v.en = en; v.fn = fn; v.af = af; v.chk_dout = chk_dout; v.dout = dout;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        if_write    = v.wr;
        if_write_ce = v.wr_ce;
        if_din      = v.din;
        if_read     = v.rd;
        if_read_ce  = v.rd_ce;
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 2'b00;
    endtask

    task automatic check(vec_t v, string tag);
        chk({tag, ".count"},   32'(if_count),       32'(v.cnt));
        chk({tag, ".empty_n"}, 32'(if_empty_n),     32'(v.en));
        chk({tag, ".full_n"},  32'(if_full_n),      32'(v.fn));
        chk({tag, ".afull"},   32'(if_almost_full), 32'(v.af));
        if (v.chk_dout) chk({tag, ".dout"}, 32'(if_dout), 32'(v.dout));
    endtask

    initial begin
        // wr ce din rd rd_ce | cnt en fn af chk dout
        vecs.push_back(mk(1, 1, 8'hA1, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'hA1));
        vecs.push_back(mk(0, 1, 8'h00, 2'b01, 2'b11, 3'd1, 2'b10, 1, 0, 1, 8'hA1));
        vecs.push_back(mk(0, 1, 8'h00, 2'b01, 2'b11, 3'd1, 2'b10, 1, 0, 1, 8'hA1));
        vecs.push_back(mk(0, 1, 8'h00, 2'b10, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 8'hB1, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'hB1));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        // Fill to full, then an ignored write while full.
        vecs.push_back(mk(1, 1, 8'h01, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h01));
        vecs.push_back(mk(1, 1, 8'h02, 2'b00, 2'b11, 3'd2, 2'b11, 1, 0, 1, 8'h01));
        vecs.push_back(mk(1, 1, 8'h03, 2'b00, 2'b11, 3'd3, 2'b11, 1, 1, 1, 8'h01));
        vecs.push_back(mk(1, 1, 8'h04, 2'b00, 2'b11, 3'd4, 2'b11, 0, 1, 1, 8'h01));
        vecs.push_back(mk(1, 1, 8'h05, 2'b00, 2'b11, 3'd4, 2'b11, 0, 1, 1, 8'h01));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd3, 2'b11, 1, 1, 1, 8'h02));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd2, 2'b11, 1, 0, 1, 8'h03));
        // Simultaneous push of 0C and pop of 03.
        vecs.push_back(mk(1, 1, 8'h0C, 2'b11, 2'b11, 3'd2, 2'b11, 1, 0, 1, 8'h04));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h0C));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        // Staggered channel reads mixed with writes.
        vecs.push_back(mk(1, 1, 8'h10, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h10));
        vecs.push_back(mk(1, 1, 8'h11, 2'b01, 2'b11, 3'd2, 2'b10, 1, 0, 1, 8'h10));
        vecs.push_back(mk(1, 1, 8'h12, 2'b10, 2'b11, 3'd2, 2'b11, 1, 0, 1, 8'h11));
        vecs.push_back(mk(1, 1, 8'h13, 2'b11, 2'b11, 3'd2, 2'b11, 1, 0, 1, 8'h12));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h13));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        // Clock-enable gating on both sides.
        vecs.push_back(mk(1, 0, 8'h77, 2'b00, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 8'h20, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h20));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b01, 3'd1, 2'b10, 1, 0, 1, 8'h20));
        vecs.push_back(mk(0, 1, 8'h00, 2'b11, 2'b00, 3'd1, 2'b10, 1, 0, 1, 8'h20));
        vecs.push_back(mk(0, 1, 8'h00, 2'b10, 2'b10, 3'd0, 2'b00, 1, 0, 0, 8'h00));

        reset_n     = 1'b0;
        if_write    = 1'b0;
        if_write_ce = 1'b1;
        if_din      = '0;
        if_read     = 2'b00;
        if_read_ce  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check(mk(0, 1, 8'h00, 2'b00, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00), "reset");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check(vecs[i], $sformatf("v%0d", i));
        end

        // Mid-operation reset with three tokens queued and channel 0 already done.
        apply(mk(1, 1, 8'h30, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h30));
        apply(mk(1, 1, 8'h31, 2'b00, 2'b11, 3'd2, 2'b11, 1, 0, 1, 8'h30));
        apply(mk(1, 1, 8'h32, 2'b01, 2'b11, 3'd3, 2'b10, 1, 1, 1, 8'h30));
        check(mk(0, 1, 8'h00, 2'b00, 2'b11, 3'd3, 2'b10, 1, 1, 1, 8'h30), "pre_rst");
        reset_n = 1'b0;
        apply(mk(1, 1, 8'h33, 2'b11, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00));
        check(mk(0, 1, 8'h00, 2'b00, 2'b11, 3'd0, 2'b00, 1, 0, 0, 8'h00), "mid_rst");
        reset_n = 1'b1;
        apply(mk(1, 1, 8'h40, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h40));
        check(mk(0, 1, 8'h00, 2'b00, 2'b11, 3'd1, 2'b11, 1, 0, 1, 8'h40), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
